// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU. The quotient goes to LO and the remainder to HI.
// It divides the operand magnitudes one bit per cycle, then applies a single sign-fix cycle.
module div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dz
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] divs_q, divs_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] q_res_q, q_res_d;
  logic [WIDTH-1:0] r_res_q, r_res_d;
  logic             dz_res_q, dz_res_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Shift the top quotient bit into the remainder, then trial-subtract the divisor.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, divs_q};
  assign a_mag   = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag   = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divs_d    = divs_q;
    raw_d     = raw_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    q_res_d   = q_res_q;
    r_res_d   = r_res_q;
    dz_res_d  = dz_res_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          neg_quo_d = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = sign & dividend[WIDTH-1];
          raw_d     = dividend;
          zero_d    = (divisor == '0);
          quo_d     = a_mag;
          divs_d    = b_mag;
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (zero_q) begin
          q_res_d  = '1;
          r_res_d  = raw_q;
          dz_res_d = 1'b1;
        end else begin
          q_res_d  = neg_quo_q ? -quo_q : quo_q;
          r_res_d  = neg_rem_q ? -rem_q : rem_q;
          dz_res_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divs_q    <= '0;
      raw_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      q_res_q   <= '0;
      r_res_q   <= '0;
      dz_res_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divs_q    <= divs_d;
      raw_q     <= raw_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      q_res_q   <= q_res_d;
      r_res_q   <= r_res_d;
      dz_res_q  <= dz_res_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign q    = q_res_q;
  assign r    = r_res_q;
  assign dz   = dz_res_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit. It checks latency and busy length, and compares results
// against an arithmetic model that uses 64-bit signed division.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        dz;

  int errors = 0;
  int checks = 0;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .dz       (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MIPS semantics: truncate toward zero, the remainder takes the dividend's sign.
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eq, output logic [31:0] er,
                                  output logic edz);
    longint sa, sb;
    if (b == 32'd0) begin
      eq = 32'hFFFF_FFFF; er = a; edz = 1'b1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eq = 32'(sa / sb); er = 32'(sa % sb); edz = 1'b0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
  endfunction

  // Drive a request at the current negedge; it is accepted on the next rising edge.
  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; sign = sgn; dividend = a; divisor = b;
  endtask

  task automatic finish_op(input string name, input logic [31:0] eq, input logic [31:0] er,
                           input logic edz, input bit poke);
    int n = 0;
    int busy_cnt = 0;
    @(negedge clk);
    start = 1'b0; sign = 1'($urandom); dividend = $urandom; divisor = $urandom;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      if (poke && n == 5) begin
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
      end
      if (poke && n == 8) start = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 33) begin errors++; $display("FAIL %s latency: got %0d want 33", name, n); end
    checks++;
    if (busy_cnt != 33) begin
      errors++; $display("FAIL %s busy_cycles: got %0d want 33", name, busy_cnt);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy); end
    checks++;
    if (q !== eq) begin errors++; $display("FAIL %s q: got %h want %h", name, q, eq); end
    checks++;
    if (r !== er) begin errors++; $display("FAIL %s r: got %h want %h", name, r, er); end
    checks++;
    if (dz !== edz) begin errors++; $display("FAIL %s dz: got %b want %b", name, dz, edz); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, q, r, dz} !== '0) begin
      errors++; $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                         busy, done, q, r, dz);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    issue(1'b0, 32'd100, 32'd7);
    finish_op("divu_100_7", 32'd14, 32'd2, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", done); end
    checks++;
    if (q !== 32'd14) begin errors++; $display("FAIL q_hold: got %h want %h", q, 32'd14); end
  endtask

  task automatic test_signed();
    issue(1'b1, -32'sd7, 32'sd2);
    finish_op("div_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(1'b1, 32'sd7, -32'sd2);
    finish_op("div_7_m2", 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    issue(1'b1, -32'sd7, -32'sd2);
    finish_op("div_m7_m2", 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
  endtask

  task automatic test_corners();
    issue(1'b0, 32'hFFFF_FFFF, 32'd1);
    finish_op("divu_max_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_overflow", 32'h8000_0000, 32'd0, 1'b0, 1'b0);
    issue(1'b0, 32'd5, 32'd9);
    finish_op("divu_5_9", 32'd0, 32'd5, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    issue(1'b1, 32'h1234_5678, 32'd0);
    finish_op("div_by_zero", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
    issue(1'b0, 32'd9, 32'd3);
    finish_op("dz_clear", 32'd3, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignore();
    issue(1'b0, 32'd77, 32'd10);
    finish_op("busy_ignore", 32'd7, 32'd7, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'd200, 32'd9);
    finish_op("b2b_first", 32'd22, 32'd2, 1'b0, 1'b0);
    issue(1'b1, -32'sd100, 32'sd7);
    finish_op("b2b_second", 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int seen = 0;
    issue(1'b0, 32'd1234, 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, q, r, dz} !== '0) begin
      errors++; $display("FAIL midop_reset: got busy=%b done=%b q=%h r=%h dz=%b want all 0",
                         busy, done, q, r, dz);
    end
    repeat (2) begin @(negedge clk); if (done) seen++; end
    rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midop_no_done: got %0d pulses want 0", seen); end
    issue(1'b0, 32'd50, 32'd5);
    finish_op("after_reset", 32'd10, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b, eq, er;
    logic        edz;
    bit          sgn;
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 15);
        1:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      ref_div(sgn, a, b, eq, er, edz);
      issue(sgn, a, b);
      finish_op($sformatf("rand%0d", i), eq, er, edz, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_corners();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle sequential integer divider for the MIPS54 datapath; executes DIV and DIVU, the inverse of the combinational ALU's arithmetic.
- Radix-2 restoring algorithm on operand magnitudes, one quotient bit per cycle, followed by a sign-fix cycle.
- Quotient goes to LO, remainder to HI. The pipeline controller stalls on busy and captures results on done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- dividend  input  WIDTH  operand a; sampled with start.
- divisor  input  WIDTH  operand b; sampled with start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse: q, r and dz are valid from this cycle on.
- q  output  WIDTH  quotient (to LO).
- r  output  WIDTH  remainder (to HI).
- dz  output  1  divisor was zero for the last completed division.

Behaviour:
- Reset: when rst_n is low, asynchronously force state IDLE, busy=0, done=0, q=0, r=0, dz=0, and clear the counter and internal registers. This applies at any point, including mid-division; the in-flight operation is discarded with no done pulse.
- States:
  - IDLE: start=1 at edge k latches sign, the raw dividend, neg_q = sign & (a[W-1]^b[W-1]), neg_r = sign & a[W-1], and the magnitudes |a| and |b| (two's-complement negation when sign=1 and the MSB is set; raw operands otherwise). It clears the partial remainder, sets counter=0 and busy=1, and moves to CALC.
  - CALC: one iteration per edge. Shift {rem, quo} left by 1 and trial-subtract |b| from rem. If there is no borrow, keep the difference and set the quo LSB to 1; otherwise restore rem and set the LSB to 0. The subtraction is WIDTH+1 bits wide. After exactly WIDTH iterations (edges k+1..k+WIDTH), move to FIX.
  - FIX: at edge k+WIDTH+1:
    - q = neg_q ? -quo : quo
    - r = neg_r ? -rem : rem
    - dz = 0
    - busy=0, done=1, return to IDLE.
- Latency: done is high in the cycle following edge k+WIDTH+1, i.e. 33 cycles after the accepting edge for WIDTH=32. busy is high for exactly WIDTH+1 cycles.
- done is a single-cycle pulse and deasserts at the next edge unless another completion occurs.
- q, r and dz hold their values until the next FIX. They are not cleared on start.
- start while busy=1 is ignored, with no queuing. start in the same cycle done=1 is accepted (state is IDLE), giving back-to-back operation with no dead cycle.
- Divide by zero (divisor==0, checked at accept): the full latency is still taken. At FIX the outputs are forced to q = all ones, r = the latched raw dividend, dz=1. The sign-fix path is bypassed.
- Signed overflow (-2^(W-1) / -1): no special case. The magnitude path yields q = 0x80000000, r = 0, dz = 0.
- Rounding follows MIPS semantics:
  - The quotient truncates toward zero.
  - A nonzero remainder takes the sign of the dividend.
  - The invariant dividend == q*divisor + r (mod 2^W) holds whenever divisor != 0.
- Unsigned mode treats all bits as magnitude; no negation is applied.
- Operand ports may change freely after the accepting edge; results depend only on the latched copies.

Test Plan:
- Unsigned basic: DIVU 100 / 7 -> done exactly 33 cycles after accept, q=14, r=2, dz=0; busy high for 33 cycles.
- Signed sign matrix: DIV -7/2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1); 7/-2 -> q=-3, r=1; -7/-2 -> q=3, r=-1.
- Corners:
  - DIVU 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
  - DIV 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
  - DIVU 5 / 9 -> q=0, r=5.
- Divide by zero: DIV 0x12345678 / 0 -> after 33 cycles q=0xFFFFFFFF, r=0x12345678, dz=1; a following DIVU 9/3 clears dz and gives q=3, r=0.
- Handshake:
  - start re-asserted with different operands during busy -> ignored, first result unchanged.
  - start held high in the done cycle -> second division accepted at once, its done 33 cycles later.
- Reset mid-op: drop rst_n during CALC iteration 10 -> busy, done, q, r, dz = 0 immediately, with no done pulse. After release, a new DIVU 50/5 returns q=10, r=0.
